regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with write-bypass and a per-register busy scoreboard, the register file for the superscalar core. It provides NUM_RD combinational read ports and NUM_WR write ports. It tracks pending writes so that issue logic can detect RAW hazards, and a flush clears all pending state on pipeline redirect.

## Interface
Parameters:
- XLEN, 32, data width
- NUM_REGS, 32, register count (power of two, at least 2); register 0 hardwired to zero
- NUM_RD, 4, read ports
- NUM_WR, 2, write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only
- AW, $clog2(NUM_REGS), address width (derived; do not override)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- rd_addr_i  in  NUM_RD×AW  read addresses
- rd_data_o  out  NUM_RD×XLEN  read data
- rd_busy_o  out  NUM_RD  read register has a pending write
- wr_en_i  in  NUM_WR  write enables
- wr_addr_i  in  NUM_WR×AW  write addresses
- wr_data_i  in  NUM_WR×XLEN  write data
- issue_en_i  in  1  mark issue_addr_i as pending
- issue_addr_i  in  AW  destination of the issued instruction
- flush_i  in  1  clear all busy bits
- wr_conflict_o  out  1  registered flag: two or more enabled write ports targeted the same nonzero register in the previous cycle

## Operation
- Storage is regs[NUM_REGS] × XLEN plus busy[NUM_REGS].
- **Write:** a port is effective when wr_en_i[k] is set and wr_addr_i[k] ≠ 0. It updates regs on the rising edge.
- **Write collision:** if several effective ports target the same register, the highest-index port wins. wr_conflict_o is 1 on the following cycle.
- **Read, address 0:** returns 0, with rd_busy_o = 0.
- **Read, BYPASS = 1:** if any effective write targets the address this cycle, return the winning port's wr_data_i. Otherwise return regs.
- **Read, BYPASS = 0:** always return regs.
- **Busy clear:** an effective write to register r clears busy[r] at the edge.
- **Busy set:** issue_en_i with issue_addr_i ≠ 0 sets busy[issue_addr_i] at the edge.
- **Set vs. clear:** when a set and a clear hit the same register in the same cycle, set wins (a new producer supersedes the retiring one).
- **Flush:** flush_i clears every busy bit. It overrides issue_en_i in the same cycle. Writes still update regs.
- **rd_busy_o:**
  - BYPASS = 1: busy[a] masked off when an effective write to a hits this cycle.
  - BYPASS = 0: raw busy[a].
- **Reset** (rst_n low at an edge): all regs = 0, all busy = 0, wr_conflict_o = 0. Reset overrides writes, issue and flush in that cycle.

## Timing
- Reads are combinational: zero-cycle latency from rd_addr_i, and from wr_* when BYPASS = 1.
- Writes, busy updates and wr_conflict_o update on the rising edge only.
- A write becomes visible through regs on the cycle after the edge. With BYPASS = 1 it is also visible in the same cycle.
- An issue sets busy, which becomes visible on rd_busy_o from the next cycle.
- Reset values:
  - rd_data_o = 0 for all addresses after reset.
  - rd_busy_o = 0.
  - wr_conflict_o = 0.
- No handshakes and no stalls: every request is accepted in every cycle.

## Test plan
- **Reset:** write 0xDEAD_BEEF to x5, assert rst_n low for one edge, then read x5 → 0, rd_busy_o = 0, wr_conflict_o = 0.
- **Bypass:** BYPASS = 1, port 0 writes x7 = 0x1234 while port 2 reads x7 in the same cycle → 0x1234. With BYPASS = 0, the same stimulus → old value, then 0x1234 on the next cycle.
- **Collision:** port 0 writes x3 = 0xAAAA and port 1 writes x3 = 0x5555 in the same cycle → x3 = 0x5555 afterwards, wr_conflict_o = 1 for exactly one cycle.
- **x0:** write 0xFFFF_FFFF to x0 and issue x0 → read x0 = 0, rd_busy_o = 0, wr_conflict_o stays 0 even if both write ports target x0.
- **Scoreboard:** issue x9 → rd_busy_o = 1 next cycle. Then issue x9 and write x9 in the same cycle → remains busy. Then write x9 alone → busy drops, masked in the write cycle when BYPASS = 1.
- **Flush:** set busy on x1–x31, then assert flush_i together with issue_en_i on x4 → all busy = 0 on the next cycle, including x4.

Source files
------------

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Multi-port integer register file for the superscalar core. It has
// NUM_RD combinational read ports, NUM_WR write ports, optional same-cycle
// write forwarding (BYPASS) and a per-register busy scoreboard that issue
// logic uses to detect RAW hazards. Register 0 always reads as zero and is
// never marked busy.
//
// Ports:
//   clk            clock
//   rst_n          synchronous, active-low reset
//   rd_addr_i      [NUM_RD][AW]    read addresses
//   rd_data_o      [NUM_RD][XLEN]  read data (combinational)
//   rd_busy_o      [NUM_RD]        register being read has a pending write
//   wr_en_i        [NUM_WR]        write enables
//   wr_addr_i      [NUM_WR][AW]    write addresses
//   wr_data_i      [NUM_WR][XLEN]  write data
//   issue_en_i                     mark issue_addr_i as pending
//   issue_addr_i   [AW]            destination of the issued instruction
//   flush_i                        clear every busy bit (pipeline redirect)
//   wr_conflict_o                  registered: two or more effective write
//                                  ports hit the same register last cycle
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 4,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD-1:0][AW-1:0]      rd_addr_i,
    output logic [NUM_RD-1:0][XLEN-1:0]    rd_data_o,
    output logic [NUM_RD-1:0]              rd_busy_o,
    input  logic [NUM_WR-1:0]              wr_en_i,
    input  logic [NUM_WR-1:0][AW-1:0]      wr_addr_i,
    input  logic [NUM_WR-1:0][XLEN-1:0]    wr_data_i,
    input  logic                           issue_en_i,
    input  logic [AW-1:0]                  issue_addr_i,
    input  logic                           flush_i,
    output logic                           wr_conflict_o
);

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                wr_conflict_q;
    logic                wr_conflict_d;

    // A write port only counts when enabled and not aimed at x0.
    logic [NUM_WR-1:0]   wr_eff;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : g_wr_eff
            assign wr_eff[gi] = wr_en_i[gi] && (wr_addr_i[gi] != '0);
        end
    endgenerate

    // Ports are applied in ascending order so the highest-index port wins
    // when several target the same register.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_eff[k]) begin
                regs_d[wr_addr_i[k]] = wr_data_i[k];
            end
        end
    end

    // Clear for retiring writes first, then set for the new producer so that
    // a set on the same register supersedes the clear. Flush beats both.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_eff[k]) begin
                busy_d[wr_addr_i[k]] = 1'b0;
            end
        end
        if (issue_en_i && (issue_addr_i != '0)) begin
            busy_d[issue_addr_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
    end

    always_comb begin
        wr_conflict_d = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (wr_eff[j] && wr_eff[k] && (wr_addr_i[j] == wr_addr_i[k])) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign wr_conflict_o = wr_conflict_q;

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [XLEN-1:0] stored;
            logic            is_zero;

            assign stored  = regs_q[rd_addr_i[gi]];
            assign is_zero = (rd_addr_i[gi] == '0);

            if (BYPASS != 0) begin : g_byp
                logic            hit;
                logic [XLEN-1:0] fwd;

                // Later ports overwrite earlier matches, mirroring the
                // write-side priority.
                always_comb begin
                    hit = 1'b0;
                    fwd = '0;
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (wr_eff[k] && (wr_addr_i[k] == rd_addr_i[gi])) begin
                            hit = 1'b1;
                            fwd = wr_data_i[k];
                        end
                    end
                end

                assign rd_data_o[gi] = is_zero ? '0 : (hit ? fwd : stored);
                // The value being written this cycle is the one the reader
                // waited for, so the pending flag is hidden.
                assign rd_busy_o[gi] = !is_zero && busy_q[rd_addr_i[gi]] && !hit;
            end else begin : g_nobyp
                assign rd_data_o[gi] = is_zero ? '0 : stored;
                assign rd_busy_o[gi] = !is_zero && busy_q[rd_addr_i[gi]];
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int AW     = 5;
    localparam int NUM_RD = 4;
    localparam int NUM_WR = 2;

    logic                          clk;
    logic                          rst_n;
    logic [NUM_RD-1:0][AW-1:0]     rd_addr;
    logic [NUM_RD-1:0][XLEN-1:0]   rd_data_b;
    logic [NUM_RD-1:0][XLEN-1:0]   rd_data_nb;
    logic [NUM_RD-1:0]             rd_busy_b;
    logic [NUM_RD-1:0]             rd_busy_nb;
    logic [NUM_WR-1:0]             wr_en;
    logic [NUM_WR-1:0][AW-1:0]     wr_addr;
    logic [NUM_WR-1:0][XLEN-1:0]   wr_data;
    logic                          issue_en;
    logic [AW-1:0]                 issue_addr;
    logic                          flush;
    logic                          conf_b;
    logic                          conf_nb;

    int n_pass  = 0;
    int n_total = 0;

    regfile_mp #(.BYPASS(1)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data_b),
        .rd_busy_o    (rd_busy_b),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .issue_en_i   (issue_en),
        .issue_addr_i (issue_addr),
        .flush_i      (flush),
        .wr_conflict_o(conf_b)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data_nb),
        .rd_busy_o    (rd_busy_nb),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .issue_en_i   (issue_en),
        .issue_addr_i (issue_addr),
        .flush_i      (flush),
        .wr_conflict_o(conf_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record = inputs held for one cycle plus the outputs expected just
    // before the closing edge, on every read port (all ports read ra).
    typedef struct {
        string        nm;
        bit           rst;
        bit [1:0]     wen;
        bit [4:0]     wa0;
        bit [31:0]    wd0;
        bit [4:0]     wa1;
        bit [31:0]    wd1;
        bit           iss;
        bit [4:0]     ia;
        bit           fl;
        bit [4:0]     ra;
        bit [31:0]    ed_b;
        bit           eb_b;
        bit [31:0]    ed_nb;
        bit           eb_nb;
        bit           ec;
    } vec_t;

    function automatic vec_t mk(string nm, int rst, int wen, int a0, int d0,
                                int a1, int d1, int iss, int ia, int fl, int ra,
                                int edb, int ebb, int ednb, int ebnb, int ec);
        vec_t v;
        v.nm    = nm;
        v.rst   = 1'(rst);
        v.wen   = 2'(wen);
        v.wa0   = 5'(a0);
        v.wd0   = 32'(d0);
        v.wa1   = 5'(a1);
        v.wd1   = 32'(d1);
        v.iss   = 1'(iss);
        v.ia    = 5'(ia);
        v.fl    = 1'(fl);
        v.ra    = 5'(ra);
        v.ed_b  = 32'(edb);
        v.eb_b  = 1'(ebb);
        v.ed_nb = 32'(ednb);
        v.eb_nb = 1'(ebnb);
        v.ec    = 1'(ec);
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(vec_t v);
        rst_n      = v.rst;
        wr_en      = v.wen;
        wr_addr[0] = v.wa0;
        wr_data[0] = v.wd0;
        wr_addr[1] = v.wa1;
        wr_data[1] = v.wd1;
        issue_en   = v.iss;
        issue_addr = v.ia;
        flush      = v.fl;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_addr[p] = v.ra;
        end
    endtask

    task automatic check_all(string nm, logic [31:0] ed_b, logic eb_b,
                             logic [31:0] ed_nb, logic eb_nb, logic ec);
        for (int p = 0; p < NUM_RD; p++) begin
            chk($sformatf("%s.p%0d.data_b", nm, p), rd_data_b[p], ed_b);
            chk($sformatf("%s.p%0d.busy_b", nm, p), 32'(rd_busy_b[p]), 32'(eb_b));
            chk($sformatf("%s.p%0d.data_nb", nm, p), rd_data_nb[p], ed_nb);
            chk($sformatf("%s.p%0d.busy_nb", nm, p), 32'(rd_busy_nb[p]), 32'(eb_nb));
        end
        chk($sformatf("%s.conf_b", nm), 32'(conf_b), 32'(ec));
        chk($sformatf("%s.conf_nb", nm), 32'(conf_nb), 32'(ec));
    endtask

    vec_t vecs[21];
    vec_t idle;

    initial begin
        //             name                  rst wen a0 d0           a1 d1           iss ia fl ra  ed_b         eb ed_nb        eb ec
        vecs[0]  = mk("wr_x5_pre_reset",     1, 1,  5, 32'hDEADBEEF, 0, 0,           0,  0, 0, 5,  32'hDEADBEEF, 0, 0,           0, 0);
        vecs[1]  = mk("reset_with_traffic",  0, 3,  6, 1,            6, 2,           1,  5, 0, 5,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0);
        vecs[2]  = mk("post_reset_x5",       1, 0,  0, 0,            0, 0,           0,  0, 0, 5,  0,            0, 0,           0, 0);
        vecs[3]  = mk("post_reset_x6",       1, 0,  0, 0,            0, 0,           0,  0, 0, 6,  0,            0, 0,           0, 0);
        vecs[4]  = mk("bypass_x7",           1, 1,  7, 32'h1234,     0, 0,           0,  0, 0, 7,  32'h1234,     0, 0,           0, 0);
        vecs[5]  = mk("x7_stored",           1, 0,  0, 0,            0, 0,           0,  0, 0, 7,  32'h1234,     0, 32'h1234,    0, 0);
        vecs[6]  = mk("bypass_p1_x7",        1, 2,  0, 0,            7, 32'h5678,    0,  0, 0, 7,  32'h5678,     0, 32'h1234,    0, 0);
        vecs[7]  = mk("x7_new",              1, 0,  0, 0,            0, 0,           0,  0, 0, 7,  32'h5678,     0, 32'h5678,    0, 0);
        vecs[8]  = mk("collide_x3",          1, 3,  3, 32'hAAAA,     3, 32'h5555,    0,  0, 0, 3,  32'h5555,     0, 0,           0, 0);
        vecs[9]  = mk("conflict_flag",       1, 0,  0, 0,            0, 0,           0,  0, 0, 3,  32'h5555,     0, 32'h5555,    0, 1);
        vecs[10] = mk("conflict_drop",       1, 0,  0, 0,            0, 0,           0,  0, 0, 3,  32'h5555,     0, 32'h5555,    0, 0);
        vecs[11] = mk("distinct_targets",    1, 3, 10, 32'hA,       11, 32'hB,       0,  0, 0, 10, 32'hA,        0, 0,           0, 0);
        vecs[12] = mk("x11_stored",          1, 0,  0, 0,            0, 0,           0,  0, 0, 11, 32'hB,        0, 32'hB,       0, 0);
        vecs[13] = mk("x0_writes",           1, 3,  0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 1, 0, 0, 0,  0,            0, 0,           0, 0);
        vecs[14] = mk("x0_after",            1, 0,  0, 0,            0, 0,           0,  0, 0, 0,  0,            0, 0,           0, 0);
        vecs[15] = mk("masked_port1",        1, 1, 12, 32'hC,       12, 32'hD,       0,  0, 0, 12, 32'hC,        0, 0,           0, 0);
        vecs[16] = mk("x12_stored",          1, 0,  0, 0,            0, 0,           0,  0, 0, 12, 32'hC,        0, 32'hC,       0, 0);
        vecs[17] = mk("issue_x9",            1, 0,  0, 0,            0, 0,           1,  9, 0, 9,  0,            0, 0,           0, 0);
        vecs[18] = mk("issue_and_write_x9",  1, 1,  9, 32'h99,       0, 0,           1,  9, 0, 9,  32'h99,       0, 0,           1, 0);
        vecs[19] = mk("retire_x9",           1, 2,  0, 0,            9, 32'h77,      0,  0, 0, 9,  32'h77,       0, 32'h99,      1, 0);
        vecs[20] = mk("x9_free",             1, 0,  0, 0,            0, 0,           0,  0, 0, 9,  32'h77,       0, 32'h77,      0, 0);

        idle = mk("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Hold reset over the first edges; state is unknown until then.
        drive(idle);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        $display("vec init_reset applied");

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            check_all(vecs[i].nm, vecs[i].ed_b, vecs[i].eb_b, vecs[i].ed_nb,
                      vecs[i].eb_nb, vecs[i].ec);
            $display("vec %0d %s ra=%0d data_b=%h busy_b=%b data_nb=%h busy_nb=%b conf=%b",
                     i, vecs[i].nm, vecs[i].ra, rd_data_b[2], rd_busy_b[2],
                     rd_data_nb[2], rd_busy_nb[2], conf_b);
        end

        // Scoreboard fill: issue every register x1..x31.
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            drive(idle);
            issue_en   = 1'b1;
            issue_addr = 5'(a);
            $display("issue x%0d", a);
        end

        // Every register must now read busy.
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            drive(idle);
            for (int p = 0; p < NUM_RD; p++) rd_addr[p] = 5'(a);
            #2;
            chk($sformatf("filled_x%0d.busy_b", a), 32'(rd_busy_b[1]), 32'd1);
            chk($sformatf("filled_x%0d.busy_nb", a), 32'(rd_busy_nb[3]), 32'd1);
            $display("filled x%0d busy_b=%b busy_nb=%b", a, rd_busy_b[1], rd_busy_nb[3]);
        end

        // Flush with a simultaneous issue of x4 and a write to x8.
        @(negedge clk);
        drive(idle);
        flush      = 1'b1;
        issue_en   = 1'b1;
        issue_addr = 5'd4;
        wr_en      = 2'b01;
        wr_addr[0] = 5'd8;
        wr_data[0] = 32'h88;
        for (int p = 0; p < NUM_RD; p++) rd_addr[p] = 5'd4;
        #2;
        chk("flush_cycle.busy_b", 32'(rd_busy_b[0]), 32'd1);
        chk("flush_cycle.busy_nb", 32'(rd_busy_nb[0]), 32'd1);
        $display("flush+issue x4 busy_b=%b busy_nb=%b", rd_busy_b[0], rd_busy_nb[0]);

        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            drive(idle);
            for (int p = 0; p < NUM_RD; p++) rd_addr[p] = 5'(a);
            #2;
            chk($sformatf("flushed_x%0d.busy_b", a), 32'(rd_busy_b[2]), 32'd0);
            chk($sformatf("flushed_x%0d.busy_nb", a), 32'(rd_busy_nb[2]), 32'd0);
            if (a == 8) begin
                chk("flushed_x8.data_b", rd_data_b[2], 32'h88);
                chk("flushed_x8.data_nb", rd_data_nb[2], 32'h88);
            end
            $display("flushed x%0d busy_b=%b busy_nb=%b data_b=%h",
                     a, rd_busy_b[2], rd_busy_nb[2], rd_data_b[2]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
